// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer, the PC register and instruction memory.
// The sequencer uses the master side; the environment uses the slave side.
interface fetch_seq_if;
    logic       run;
    logic [3:0] PC_out;
    logic       zero;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       PCload;
    logic [3:0] PC_in;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic [7:0] IR;
    logic       halted;
    logic       err;

    modport master (
        input  run, PC_out, zero, mem_ack, mem_data,
        output PCload, PC_in, mem_req, mem_addr, IR, halted, err
    );

    modport slave (
        output run, PC_out, zero, mem_ack, mem_data,
        input  PCload, PC_in, mem_req, mem_addr, IR, halted, err
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetches a word, decodes SEQ/JMP/BZ/HALT,
// strobes the next PC into the PC register, and traps on fetch timeout.
module fetch_seq #(
    parameter int MAX_WAIT = 7
) (
    input  logic          clk,
    input  logic          reset,
    fetch_seq_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_UPDATE,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_BZ   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t     r_state;
    logic [3:0] r_wait;
    logic       r_pcload;
    logic [3:0] r_pc_in;
    logic       r_mem_req;
    logic [7:0] r_ir;
    logic       r_halted;
    logic       r_err;

    logic [3:0] w_wait_inc;
    logic [1:0] w_op;
    logic [3:0] w_target;

    function automatic logic [3:0] next_pc(
        input logic [3:0] pc,
        input logic [1:0] op,
        input logic [3:0] target,
        input logic       z
    );
        logic [3:0] seq_pc;
        seq_pc = pc + 4'd1;
        case (op)
            OP_JMP:  next_pc = target;
            OP_BZ:   next_pc = z ? target : seq_pc;
            default: next_pc = seq_pc;
        endcase
    endfunction

    assign w_wait_inc = r_wait + 4'd1;
    assign w_op       = bus.mem_data[7:6];
    assign w_target   = bus.mem_data[3:0];

    // Memory is addressed straight from the live program counter.
    assign bus.mem_addr = bus.PC_out;
    assign bus.PCload   = r_pcload;
    assign bus.PC_in    = r_pc_in;
    assign bus.mem_req  = r_mem_req;
    assign bus.IR       = r_ir;
    assign bus.halted   = r_halted;
    assign bus.err      = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= 4'd0;
            r_pcload  <= 1'b0;
            r_pc_in   <= 4'd0;
            r_mem_req <= 1'b0;
            r_ir      <= 8'd0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                        r_wait    <= 4'd0;
                    end
                end
                S_FETCH: begin
                    // An ack arriving on the timeout edge wins over the timeout.
                    if (bus.mem_ack) begin
                        r_ir      <= bus.mem_data;
                        r_wait    <= 4'd0;
                        r_mem_req <= 1'b0;
                        if (w_op == OP_HALT) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc_in  <= next_pc(bus.PC_out, w_op, w_target, bus.zero);
                            r_pcload <= 1'b1;
                            r_state  <= S_UPDATE;
                        end
                    end else if (w_wait_inc == 4'(MAX_WAIT)) begin
                        r_wait    <= w_wait_inc;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                S_UPDATE: begin
                    r_pcload <= 1'b0;
                    if (bus.run) begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pcload  <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: table-driven decode vectors with a
// PC_in scoreboard, plus hand-written halt, timeout, reset and run sequences.
module tb_fetch_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_q[$];

    fetch_seq_if bus();

    fetch_seq #(.MAX_WAIT(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] instr;
        logic       z;
        logic [3:0] exp_pc_in;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.run      = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && bus.mem_req !== 1'b1; i++) tick();
        chk("req_seen", bus.mem_req, 1);
    endtask

    // Called in the cycle after an accepted ack: PCload must pulse with the queued PC.
    task automatic check_update();
        chk("pcload_pulse", bus.PCload, 1);
        chk("req_off_in_update", bus.mem_req, 0);
        if (exp_q.size() > 0) begin
            chk("pc_in", bus.PC_in, exp_q.pop_front());
        end else begin
            checks++;
            errors++;
            $display("FAIL scoreboard: PCload with empty queue, PC_in=%0h", bus.PC_in);
        end
    endtask

    task automatic fetch(input logic [3:0] pc, input logic [7:0] instr, input logic z,
                         input logic push, input logic [3:0] exp_pc);
        bus.PC_out = pc;
        bus.zero   = z;
        wait_req();
        bus.mem_ack  = 1'b1;
        bus.mem_data = instr;
        if (push) exp_q.push_back(exp_pc);
        tick();
        bus.mem_ack = 1'b0;
        bus.zero    = ~z;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd3,  8'h00, 1'b0, 4'd4};
        vecs[1] = '{4'd15, 8'h00, 1'b0, 4'd0};
        vecs[2] = '{4'd0,  8'h49, 1'b0, 4'd9};
        vecs[3] = '{4'd2,  8'h85, 1'b1, 4'd5};
        vecs[4] = '{4'd2,  8'h85, 1'b0, 4'd3};
        vecs[5] = '{4'd7,  8'h4F, 1'b1, 4'd15};
        vecs[6] = '{4'd9,  8'h80, 1'b0, 4'd10};
        vecs[7] = '{4'd4,  8'h8C, 1'b1, 4'd12};

        bus.PC_out = 4'd0;
        bus.zero   = 1'b0;
        do_reset();
        chk("rst_pcload", bus.PCload, 0);
        chk("rst_pc_in", bus.PC_in, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_ir", bus.IR, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_err", bus.err, 0);

        // Back-to-back decode table with run held high.
        bus.run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.PC_out = vecs[i].pc;
            #1;
            chk("mem_addr", bus.mem_addr, {28'd0, vecs[i].pc});
            fetch(vecs[i].pc, vecs[i].instr, vecs[i].z, 1'b1, vecs[i].exp_pc_in);
            check_update();
            chk("ir_latch", bus.IR, {24'd0, vecs[i].instr});
            tick();
            chk("pcload_one_cycle", bus.PCload, 0);
            chk("two_cycle_throughput", bus.mem_req, 1);
        end

        // Halt is terminal and never loads the PC.
        do_reset();
        bus.run = 1'b1;
        fetch(4'd5, 8'hC0, 1'b0, 1'b0, 4'd0);
        chk("halt_halted", bus.halted, 1);
        chk("halt_no_pcload", bus.PCload, 0);
        chk("halt_no_req", bus.mem_req, 0);
        chk("halt_ir", bus.IR, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = i[0];
            tick();
            chk("halt_stays_quiet", {bus.PCload, bus.mem_req, bus.halted}, 3'b001);
        end
        bus.mem_ack = 1'b0;
        do_reset();
        chk("halt_cleared", bus.halted, 0);

        // Timeout after seven FETCH cycles without ack.
        bus.run = 1'b1;
        bus.PC_out = 4'd1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            chk("to_req_held", bus.mem_req, 1);
            tick();
        end
        chk("to_not_yet", bus.err, 0);
        chk("to_req_cycle7", bus.mem_req, 1);
        tick();
        chk("to_err", bus.err, 1);
        chk("to_req_off", bus.mem_req, 0);
        repeat (3) tick();
        chk("to_sticky", {bus.err, bus.mem_req, bus.PCload}, 3'b100);
        do_reset();
        chk("to_cleared", bus.err, 0);

        // Ack on the seventh cycle is accepted.
        bus.run = 1'b1;
        bus.PC_out = 4'd6;
        tick();
        repeat (6) tick();
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h00;
        exp_q.push_back(4'd7);
        tick();
        bus.mem_ack = 1'b0;
        chk("late_ack_no_err", bus.err, 0);
        check_update();

        // Reset mid-fetch overrides run and ack.
        do_reset();
        bus.run = 1'b1;
        fetch(4'd2, 8'h4A, 1'b0, 1'b1, 4'd10);
        check_update();
        tick();
        chk("pre_reset_req", bus.mem_req, 1);
        reset        = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h4C;
        tick();
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        bus.run     = 1'b0;
        chk("midrst_outputs", {bus.PCload, bus.PC_in, bus.mem_req, bus.IR, bus.halted, bus.err}, 0);
        tick();
        chk("midrst_idle", bus.mem_req, 0);

        // run dropped during FETCH does not abort the instruction.
        bus.run = 1'b1;
        tick();
        chk("rf_fetch", bus.mem_req, 1);
        bus.run = 1'b0;
        fetch(4'd8, 8'h00, 1'b0, 1'b1, 4'd9);
        check_update();
        tick();
        chk("rf_exit", {bus.mem_req, bus.PCload}, 2'b00);
        tick();
        chk("rf_idle", bus.mem_req, 0);

        // Ack outside FETCH is ignored.
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'hC3;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_ir", bus.IR, 8'h00);
        chk("stray_ack_halt", bus.halted, 0);

        // run dropped during UPDATE returns to IDLE after the pulse.
        bus.run = 1'b1;
        tick();
        fetch(4'd1, 8'h4E, 1'b0, 1'b0, 4'd0);
        exp_q.push_back(4'd14);
        bus.run = 1'b0;
        check_update();
        tick();
        chk("ru_exit", {bus.mem_req, bus.PCload}, 2'b00);
        tick();
        chk("ru_idle", bus.mem_req, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter MAX_WAIT, default 7, SHALL set the maximum number of FETCH cycles allowed without mem_ack before an error is declared (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 run  input  1  SHALL be the start/continue enable.
REQ-005 PC_out  input  4  SHALL be the current program counter from the PC register.
REQ-006 zero  input  1  SHALL be the condition flag for conditional branch.
REQ-007 mem_ack  input  1  SHALL be the instruction-memory acknowledge.
REQ-008 mem_data  input  8  SHALL be the instruction word, valid when mem_ack=1.
REQ-009 PCload  output  1  SHALL be the registered load strobe to the PC register.
REQ-010 PC_in  output  4  SHALL be the registered next-PC value to the PC register.
REQ-011 mem_req  output  1  SHALL be the registered instruction-fetch request.
REQ-012 mem_addr  output  4  SHALL equal PC_out combinationally.
REQ-013 IR  output  8  SHALL be the registered last fetched instruction.
REQ-014 halted  output  1  SHALL be the registered sticky halt indicator.
REQ-015 err  output  1  SHALL be the registered sticky fetch-timeout indicator.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, UPDATE, HALT and ERR.
REQ-017 IDLE: when run=1, the FSM SHALL go to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 FETCH: mem_req SHALL be 1 and a wait counter SHALL increment each cycle without mem_ack.
REQ-019 FETCH with mem_ack=1: the FSM SHALL latch IR<=mem_data, sample zero, compute PC_in, reset the wait counter and go to UPDATE.
REQ-020 Opcode IR[7:6]=00 (SEQ): PC_in SHALL be (PC_out+1) mod 16, so 15 wraps to 0.
REQ-021 Opcode 01 (JMP): PC_in SHALL be IR[3:0].
REQ-022 Opcode 10 (BZ): PC_in SHALL be IR[3:0] if the sampled zero=1, else (PC_out+1) mod 16.
REQ-023 Opcode 11 (HALT): the FSM SHALL go to HALT instead of UPDATE, set halted=1 and never assert PCload.
REQ-024 UPDATE: PCload SHALL be 1 for exactly one cycle with PC_in stable, so the PC register captures it within that cycle.
REQ-025 After UPDATE the FSM SHALL go to FETCH if run=1, else to IDLE; minimum throughput SHALL be one instruction per 2 cycles.
REQ-026 run=0 during FETCH or UPDATE SHALL NOT abort the current instruction; it SHALL take effect only at the exit from UPDATE.
REQ-027 Timeout: if the wait counter reaches MAX_WAIT in FETCH without mem_ack, the FSM SHALL go to ERR with mem_req=0 and err=1.
REQ-028 mem_ack on the same edge as the timeout SHALL count as accepted, with no error.
REQ-029 mem_ack outside FETCH SHALL be ignored.
REQ-030 HALT and ERR SHALL be terminal: run SHALL be ignored, and only reset SHALL exit.
REQ-031 PCload and mem_req SHALL never be 1 in the same cycle.

Reset
REQ-032 When reset=1 on an edge, the block SHALL enter IDLE with PCload=0, PC_in=0, mem_req=0, IR=0, halted=0, err=0 and wait counter=0, regardless of state, including mid-fetch.
REQ-033 reset SHALL take priority over run and mem_ack in the same cycle.
REQ-034 fetch_seq SHALL NOT reset the PC register; system reset SHALL drive both blocks.

Verification
REQ-035 Sequential flow: PC_out=3, run=1, ack immediately with 0x00 -> one PCload pulse with PC_in=4; 2 cycles per instruction.
REQ-036 Wrap and jump: PC_out=15 with SEQ -> PC_in=0; then JMP 0x49 -> PC_in=9.
REQ-037 Branch: BZ 0x85 at PC 2 -> PC_in=5 when zero=1 and PC_in=3 when zero=0.
REQ-038 Halt: fetch 0xC0 -> halted=1, PCload never pulses, and the block stays halted with run=1 until reset.
REQ-039 Timeout: MAX_WAIT=7, mem_ack held 0 -> err=1 after 7 FETCH cycles and mem_req=0; ack on the 7th cycle -> no error.
REQ-040 Reset mid-fetch, and run dropped during UPDATE: reset with mem_req=1 -> all outputs 0 next cycle; run=0 in UPDATE -> IDLE after the PCload pulse.
